mcpu_control_fsm: RTL
=====================

# mcpu_control_fsm

Multi-cycle control sequencer for the MCPU datapath. Takes opcode/funct from the IR and the ALU zero flag, and steps each instruction through FETCH, DECODE and per-class execute states. It drives every enable and mux select in the datapath: PC, IR, A/B, BEN, the PC+4 save register, the regfile, memory, and the ALU, PC-source, write-address and write-data muxes. It also counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `opcode`, in, 6: IR[31:26].
- `funct`, in, 6: IR[5:0].
- `pc_we`, `ir_we`, `a_we`, `b_we`, `ben`, `cheese`, `reg_we`, `mem_we`, out, 1 each: write enables. `cheese` loads the PC+4 save register.
- `memin`, `regin`, `dst`, `jal`, `beqbne`, `immer`, out, 1 each: mux selects.
  - `memin`: 0 = PC, 1 = alu_reg.
  - `regin`: 0 = alu_reg, 1 = MDR.
  - `dst`: 0 = rd, 1 = rt.
  - `jal`: 1 = write register 31.
  - `beqbne`: 1 = BNE.
  - `immer`: tied 0.
- `alusrca`, out, 2: 0 = PC, 1 = A, 2 = ben_out, 3 = 0.
- `alusrcb`, out, 2: 0 = imm<<2, 1 = sign-extended imm, 2 = B, 3 = 4.
- `pcsrc`, out, 2: 0 = branch-resolved, 1 = jump concat, 2 = pc4, 3 = alu_reg.
- `aluop`, out, 3: ADD=0, SUB=1, XOR=2, SLT=3.
- `state`, out, 4: current state, for debug.
- `instr_done`, out, 1: one-cycle pulse in the final state of each instruction.
- `illegal`, out, 1: one-cycle pulse in DECODE when the opcode/funct is unsupported.
- `instret`, out, CNT_W: retired-instruction count.

## Operation
- Outputs are Moore, decoded from `state` plus the latched opcode/funct. Every output not listed for a state is 0.
- **FETCH**: `memin`=0, `ir_we`=1, `cheese`=1, `alusrca`=0, `alusrcb`=3, ADD. Next state: DECODE.
- **DECODE**: `a_we`=`b_we`=1, `pc_we`=1 with `pcsrc`=2 (PC ← PC+4), `alusrca`=0, `alusrcb`=3, ADD (alu_reg ← old PC+4). Branches to the class state below. Unsupported instructions raise `illegal` and return to FETCH without retiring.
- **BR1**: `ben`=1 (ben_out ← PC+4), `alusrca`=0, `alusrcb`=0, ADD (alu_reg ← branch target).
- **BR2**: `alusrca`=1, `alusrcb`=2, SUB, `beqbne`=opcode[0], `pcsrc`=0, `pc_we`=1. Done.
- **J1**: `pcsrc`=1, `pc_we`=1. Done.
- **JAL1**: `pcsrc`=1, `pc_we`=1, `reg_we`=1, `jal`=1, `regin`=0 (r31 ← old PC+4). Done.
- **JR1**: `alusrca`=1, `alusrcb`=2 (rt=0, so B=0), ADD. Next state: JR2.
- **JR2**: `pcsrc`=3, `pc_we`=1. Done.
- **RX** (ADD 0x20, SUB 0x22, SLT 0x2a): `alusrca`=1, `alusrcb`=2, `aluop` taken from funct. Next state: RWB.
- **RWB**: `dst`=0, `regin`=0, `reg_we`=1. Done.
- **IX** (ADDI 0x08 → ADD, XORI 0x0e → XOR): `alusrca`=1, `alusrcb`=1. Next state: IWB. XORI uses the sign-extended immediate.
- **IWB**: `dst`=1, `regin`=0, `reg_we`=1. Done.
- **MADDR** (LW 0x23, SW 0x2b): `alusrca`=1, `alusrcb`=1, ADD. Next state: MRD for LW, MWR for SW.
- **MRD**: `memin`=1; MDR captures the read data. Next state: LWB.
- **LWB**: `dst`=1, `regin`=1, `reg_we`=1. Done.
- **MWR**: `memin`=1, `mem_we`=1. Done.
- R-type decode: opcode 0 with funct 0x08 is JR. Opcode 0x02 is J, 0x03 is JAL, 0x04 is BEQ, 0x05 is BNE.
- "Done" means: `instr_done`=1, `instret` increments (wrapping modulo 2^CNT_W), and the next state is FETCH.

## Timing
- Reset cycle:
  - All write enables are 0, including `pc_we`.
  - All selects, `illegal` and `instr_done` are 0.
  - `state` and `instret` are forced to FETCH and 0 at the edge.
- Reset asserted in any state aborts the instruction. No write enable is high while `reset`=1. The first cycle after deassertion is FETCH.
- Latency in cycles:
  - J and JAL: 3.
  - BEQ, BNE, JR, R-type, ADDI, XORI, SW: 4.
  - LW: 5.
  - Illegal: 2.
- opcode/funct are sampled from the IR from DECODE onward. The IR is stable because `ir_we` is high only in FETCH.
- BR2: the PC is written from the pre-edge alu_reg or ben_out. The SUB result overwriting alu_reg at that same edge is harmless.
- A counter wrap coincident with `instr_done` yields 0.

## Structure
- Package `mcpu_ctrl_pkg` holds:
  - state encoding, 4-bit;
  - `aluop` codes;
  - opcode and funct constants;
  - mux-select encodings for `alusrca`, `alusrcb` and `pcsrc`.
- Sub-module `mcpu_ctrl_decode` is combinational. It maps opcode/funct to an instruction class and an `illegal` flag.
- The FSM, output decode and counter live in the top module.

## Test plan
- Reset held 3 cycles mid-LW (state MRD) → `reg_we`=`mem_we`=`pc_we`=0 throughout; `instret`=0; FETCH on the first post-reset cycle.
- ADD r3,r1,r2 (0x00221820) → states FETCH, DECODE, RX, RWB; `aluop`=0 in RX; `reg_we`=1 with `dst`=0 in RWB only; `instret` 0→1.
- LW (0x8C220004) then SW (0xAC220008) → 5 then 4 cycles; `memin`=1 in MRD and MWR; `mem_we`=1 only in MWR; `regin`=1 in LWB.
- BEQ (0x10220003) then BNE (0x14220003) → BR2 has `aluop`=1 and `pcsrc`=0, with `beqbne`=0 for BEQ and 1 for BNE; `ben`=1 in BR1 only.
- JAL (0x0C000010) → JAL1 asserts `jal`=`reg_we`=`pc_we`=1 with `pcsrc`=1; 3-cycle latency. JR r31 (0x03E00008) → JR2 has `pcsrc`=3.
- Opcode 0x3F → `illegal` pulses in DECODE; next state FETCH; `instret` unchanged.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the MCPU multi-cycle control sequencer: states,
// instruction classes, ALU codes, opcode/funct constants and mux selects.
package mcpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_BR1, S_BR2, S_J1, S_JAL1, S_JR1, S_JR2,
        S_RX, S_RWB, S_IX, S_IWB, S_MADDR, S_MRD, S_LWB, S_MWR
    } state_t;

    typedef enum logic [2:0] {
        CLS_BR, CLS_J, CLS_JAL, CLS_JR, CLS_R, CLS_I, CLS_MEM, CLS_ILL
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_A    = 2'd1;
    localparam logic [1:0] SRCA_BEN  = 2'd2;
    localparam logic [1:0] SRCA_ZERO = 2'd3;

    localparam logic [1:0] SRCB_IMM4 = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_B    = 2'd2;
    localparam logic [1:0] SRCB_FOUR = 2'd3;

    localparam logic [1:0] PCSRC_BRANCH = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_PC4    = 2'd2;
    localparam logic [1:0] PCSRC_ALU    = 2'd3;

    function automatic logic [2:0] funct_aluop(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct to the execute
// class the sequencer branches to, flagging anything unsupported.
module mcpu_ctrl_decode
    import mcpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic       illegal
);

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR:                  cls = CLS_JR;
                    FN_ADD, FN_SUB, FN_SLT: cls = CLS_R;
                    default:                cls = CLS_ILL;
                endcase
            end
            OP_J:            cls = CLS_J;
            OP_JAL:          cls = CLS_JAL;
            OP_BEQ, OP_BNE:  cls = CLS_BR;
            OP_ADDI, OP_XORI: cls = CLS_I;
            OP_LW, OP_SW:    cls = CLS_MEM;
            default:         cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle MCPU control sequencer: state register, Moore output decode
// and retired-instruction counter.
module mcpu_control_fsm
    import mcpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic             pc_we,
    output logic             ir_we,
    output logic             a_we,
    output logic             b_we,
    output logic             ben,
    output logic             cheese,
    output logic             reg_we,
    output logic             mem_we,
    output logic             memin,
    output logic             regin,
    output logic             dst,
    output logic             jal,
    output logic             beqbne,
    output logic             immer,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       aluop,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     st;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [2:0] cls;
    logic       dec_illegal;

    mcpu_ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // opcode/funct are captured at the end of DECODE so later states never
    // depend on the IR bus directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            instret <= '0;
        end else begin
            case (st)
                S_FETCH: st <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    case (cls)
                        CLS_BR:  st <= S_BR1;
                        CLS_J:   st <= S_J1;
                        CLS_JAL: st <= S_JAL1;
                        CLS_JR:  st <= S_JR1;
                        CLS_R:   st <= S_RX;
                        CLS_I:   st <= S_IX;
                        CLS_MEM: st <= S_MADDR;
                        default: st <= S_FETCH;
                    endcase
                end
                S_BR1:   st <= S_BR2;
                S_JR1:   st <= S_JR2;
                S_RX:    st <= S_RWB;
                S_IX:    st <= S_IWB;
                S_MADDR: st <= (op_q == OP_LW) ? S_MRD : S_MWR;
                S_MRD:   st <= S_LWB;
                default: st <= S_FETCH;
            endcase
            if (instr_done) instret <= instret + CNT_W'(1);
        end
    end

    assign state = st;
    assign immer = 1'b0;

    // Everything is held at 0 while reset is high, whatever state the
    // aborted instruction left behind.
    always_comb begin
        pc_we = 1'b0; ir_we = 1'b0; a_we = 1'b0; b_we = 1'b0;
        ben = 1'b0; cheese = 1'b0; reg_we = 1'b0; mem_we = 1'b0;
        memin = 1'b0; regin = 1'b0; dst = 1'b0; jal = 1'b0; beqbne = 1'b0;
        alusrca = SRCA_PC; alusrcb = SRCB_IMM4; pcsrc = PCSRC_BRANCH;
        aluop = ALU_ADD; instr_done = 1'b0; illegal = 1'b0;
        if (!reset) begin
            case (st)
                S_FETCH: begin
                    ir_we = 1'b1; cheese = 1'b1; alusrcb = SRCB_FOUR;
                end
                S_DECODE: begin
                    a_we = 1'b1; b_we = 1'b1; pc_we = 1'b1; pcsrc = PCSRC_PC4;
                    alusrcb = SRCB_FOUR; illegal = dec_illegal;
                end
                S_BR1: ben = 1'b1;
                S_BR2: begin
                    alusrca = SRCA_A; alusrcb = SRCB_B; aluop = ALU_SUB;
                    beqbne = op_q[0]; pc_we = 1'b1; instr_done = 1'b1;
                end
                S_J1: begin
                    pcsrc = PCSRC_JUMP; pc_we = 1'b1; instr_done = 1'b1;
                end
                S_JAL1: begin
                    pcsrc = PCSRC_JUMP; pc_we = 1'b1; reg_we = 1'b1; jal = 1'b1;
                    instr_done = 1'b1;
                end
                S_JR1: begin
                    alusrca = SRCA_A; alusrcb = SRCB_B;
                end
                S_JR2: begin
                    pcsrc = PCSRC_ALU; pc_we = 1'b1; instr_done = 1'b1;
                end
                S_RX: begin
                    alusrca = SRCA_A; alusrcb = SRCB_B; aluop = funct_aluop(fn_q);
                end
                S_RWB: begin
                    reg_we = 1'b1; instr_done = 1'b1;
                end
                S_IX: begin
                    alusrca = SRCA_A; alusrcb = SRCB_SEXT;
                    aluop = (op_q == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                S_IWB: begin
                    dst = 1'b1; reg_we = 1'b1; instr_done = 1'b1;
                end
                S_MADDR: begin
                    alusrca = SRCA_A; alusrcb = SRCB_SEXT;
                end
                S_MRD: memin = 1'b1;
                S_LWB: begin
                    dst = 1'b1; regin = 1'b1; reg_we = 1'b1; instr_done = 1'b1;
                end
                S_MWR: begin
                    memin = 1'b1; mem_we = 1'b1; instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
